// File: rtl/product_accumulator_if.sv
// Product stream in / frame-sum out handshake bundle for product_accumulator.
// master = product source and result sink, slave = the accumulator.
interface product_accumulator_if #(
    parameter int WIDTH = 48,
    parameter int GUARD = 8,
    parameter int CNT_W = 8
);
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + GUARD;

    logic             p_valid;
    logic [PW-1:0]    p;
    logic             p_last;
    logic             p_ready;
    logic             acc_valid;
    logic [AW-1:0]    acc;
    logic [CNT_W-1:0] acc_count;
    logic             acc_ovf;
    logic             out_ready;

    modport master (
        output p_valid, p, p_last, out_ready,
        input  p_ready, acc_valid, acc, acc_count, acc_ovf
    );

    modport slave (
        input  p_valid, p, p_last, out_ready,
        output p_ready, acc_valid, acc, acc_count, acc_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums p_last-delimited frames of multiplier products into a guard-extended accumulator.
// Define ACC_SATURATE_EN to clamp the sum at all-ones on carry instead of wrapping.
module product_accumulator #(
    parameter int WIDTH = 48,
    parameter int GUARD = 8,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    product_accumulator_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + GUARD;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [AW-1:0]    acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             valid_r;
    logic             ready_r;

    logic             take;
    logic [AW:0]      sum;
    logic             carry;
    logic             cnt_full;
    logic [AW-1:0]    acc_next;

    assign take     = bus.p_valid & ready_r;
    assign sum      = {1'b0, acc_r} + {{(GUARD + 1){1'b0}}, bus.p};
    assign carry    = sum[AW];
    assign cnt_full = &cnt_r;

`ifdef ACC_SATURATE_EN
    // Once clamped, every further beat carries again, so the sum stays pinned.
    assign acc_next = carry ? {AW{1'b1}} : sum[AW-1:0];
`else
    assign acc_next = sum[AW-1:0];
`endif

    // p_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_r <= 1'b1;
                    if (take) begin
                        acc_r <= {{GUARD{1'b0}}, bus.p};
                        cnt_r <= CNT_W'(1);
                        ovf_r <= 1'b0;
                        if (bus.p_last) begin
                            state   <= HOLD;
                            valid_r <= 1'b1;
                            ready_r <= 1'b0;
                        end else begin
                            state   <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (take) begin
                        acc_r <= acc_next;
                        cnt_r <= cnt_full ? cnt_r : cnt_r + 1'b1;
                        ovf_r <= ovf_r | carry | cnt_full;
                        if (bus.p_last) begin
                            state   <= HOLD;
                            valid_r <= 1'b1;
                            ready_r <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.p_ready   = ready_r;
    assign bus.acc_valid = valid_r;
    assign bus.acc       = acc_r;
    assign bus.acc_count = cnt_r;
    assign bus.acc_ovf   = ovf_r;
endmodule

// File: tb/tb_product_accumulator.sv
// Randomized self-checking bench for product_accumulator (GUARD=1, CNT_W=2 to reach overflow cases).
module tb_product_accumulator;
    localparam int WIDTH = 48;
    localparam int GUARD = 1;
    localparam int CNT_W = 2;
    localparam int PW    = 2 * WIDTH;
    localparam int AW    = PW + GUARD;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) bus ();

    product_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a beat, waits (bounded) for p_ready, then lets the edge take it.
    task automatic send_beat(input logic [PW-1:0] v, input logic last, output bit timed_out);
        int guard = 0;
        bus.p_valid = 1'b1;
        bus.p       = v;
        bus.p_last  = last;
        while (bus.p_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        timed_out = (guard >= 50);
        step();
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit to, any_to;
        rst = 1'b1;
        bus.p_valid = 1'b0; bus.p = '0; bus.p_last = 1'b0; bus.out_ready = 1'b0;
        step(); step();
        total++;
        if (bus.acc_valid !== 1'b0 || bus.acc !== '0 || bus.acc_count !== '0 || bus.acc_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got valid=%b acc=%0h cnt=%0d ovf=%b required all 0",
                     bus.acc_valid, bus.acc, bus.acc_count, bus.acc_ovf);
        end
        rst = 1'b0;
        step();
        total++;
        if (bus.p_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_ready: got %b required 1", bus.p_ready);
        end
        send_beat(40, 1'b0, to); any_to = to;
        send_beat(50, 1'b0, to); any_to |= to;
        bus.p_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (any_to || bus.acc !== '0 || bus.acc_count !== '0 || bus.acc_valid !== 1'b0 || bus.acc_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_midframe: got acc=%0h cnt=%0d valid=%b ovf=%b timeout=%b required 0s",
                     bus.acc, bus.acc_count, bus.acc_valid, bus.acc_ovf, any_to);
        end
        #2;
        rst = 1'b0;
        step(); step();
        send_beat(9, 1'b1, to);
        bus.p_valid = 1'b0;
        total++;
        if (to || bus.acc_valid !== 1'b1 || bus.acc !== AW'(9) || bus.acc_count !== CNT_W'(1) || bus.acc_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_clean_frame: got valid=%b acc=%0h cnt=%0d ovf=%b required 1/9/1/0",
                     bus.acc_valid, bus.acc, bus.acc_count, bus.acc_ovf);
        end
        handshake();
    endtask

    task automatic test_three_beat();
        bit to, any_to;
        bus.out_ready = 1'b1;
        send_beat(5, 1'b0, to);  any_to = to;
        send_beat(7, 1'b0, to);  any_to |= to;
        send_beat(11, 1'b1, to); any_to |= to;
        bus.p_valid = 1'b0;
        bus.p_last  = 1'b0;
        total++;
        if (any_to || bus.acc_valid !== 1'b1 || bus.p_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL three_latency: got valid=%b ready=%b required 1/0", bus.acc_valid, bus.p_ready);
        end
        total++;
        if (bus.acc !== AW'(23) || bus.acc_count !== CNT_W'(3) || bus.acc_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL three_result: got acc=%0d cnt=%0d ovf=%b required 23/3/0",
                     bus.acc, bus.acc_count, bus.acc_ovf);
        end
        step();
        total++;
        if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL three_release: got valid=%b ready=%b required 0/1", bus.acc_valid, bus.p_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_single_beat();
        bit to;
        logic [PW-1:0] ones = '1;
        send_beat(ones, 1'b1, to);
        bus.p_valid = 1'b0;
        total++;
        if (to || bus.acc_valid !== 1'b1 || bus.acc !== {1'b0, ones} || bus.acc_count !== CNT_W'(1) || bus.acc_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_beat: got valid=%b acc=%0h cnt=%0d ovf=%b required 1/%0h/1/0",
                     bus.acc_valid, bus.acc, bus.acc_count, bus.acc_ovf, ones);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        bit to;
        send_beat(100, 1'b1, to);
        bus.p = 200; bus.p_last = 1'b1; bus.p_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (to || bus.p_ready !== 1'b0 || bus.acc_valid !== 1'b1 || bus.acc !== AW'(100)) begin
                bad++;
                $display("[TB] FAIL bp_hold[%0d]: got ready=%b valid=%b acc=%0d required 0/1/100",
                         i, bus.p_ready, bus.acc_valid, bus.acc);
            end
            step();
        end
        handshake();
        total++;
        if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_bubble: got valid=%b ready=%b required 0/1", bus.acc_valid, bus.p_ready);
        end
        step();
        bus.p_valid = 1'b0;
        bus.p_last  = 1'b0;
        total++;
        if (bus.acc_valid !== 1'b1 || bus.acc !== AW'(200) || bus.acc_count !== CNT_W'(1)) begin
            bad++;
            $display("[TB] FAIL bp_next_frame: got valid=%b acc=%0d cnt=%0d required 1/200/1",
                     bus.acc_valid, bus.acc, bus.acc_count);
        end
        handshake();
    endtask

    task automatic test_overflow();
        bit to, any_to;
        logic [PW-1:0] ones = '1;
        logic [AW-1:0] exp_acc;
        send_beat(ones, 1'b0, to); any_to = to;
        send_beat(ones, 1'b1, to); any_to |= to;
        bus.p_valid = 1'b0;
        exp_acc = {1'b0, ones} + {1'b0, ones};
        total++;
        if (any_to || bus.acc !== exp_acc || bus.acc_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_no_carry: got acc=%0h ovf=%b required %0h/0", bus.acc, bus.acc_ovf, exp_acc);
        end
        handshake();
        send_beat(ones, 1'b0, to); any_to = to;
        send_beat(ones, 1'b0, to); any_to |= to;
        send_beat(ones, 1'b1, to); any_to |= to;
        bus.p_valid = 1'b0;
`ifdef ACC_SATURATE_EN
        exp_acc = '1;
`else
        exp_acc = {1'b0, ones} - AW'(2);
`endif
        total++;
        if (any_to || bus.acc !== exp_acc || bus.acc_ovf !== 1'b1 || bus.acc_count !== CNT_W'(3)) begin
            bad++;
            $display("[TB] FAIL ovf_carry: got acc=%0h ovf=%b cnt=%0d required %0h/1/3",
                     bus.acc, bus.acc_ovf, bus.acc_count, exp_acc);
        end
        handshake();
    endtask

    task automatic test_counter();
        bit to, any_to;
        any_to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_beat(1, (i == 3), to);
            any_to |= to;
        end
        bus.p_valid = 1'b0;
        total++;
        if (any_to || bus.acc !== AW'(4) || bus.acc_count !== CNT_W'(3) || bus.acc_ovf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL counter_sat: got acc=%0d cnt=%0d ovf=%b required 4/3/1",
                     bus.acc, bus.acc_count, bus.acc_ovf);
        end
        handshake();
    endtask

    // Reference: exact frame sum in a wide integer, then reduce to what the outputs must show.
    task automatic test_random();
        bit to, any_to;
        logic [PW-1:0]   v;
        logic [AW+3:0]   true_sum;
        logic [AW-1:0]   exp_acc;
        logic [CNT_W-1:0] exp_cnt;
        logic            exp_ovf;
        int              nb;
        for (int f = 0; f < 25; f++) begin
            nb = $urandom_range(1, 6);
            true_sum = '0;
            any_to = 1'b0;
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.p_valid = 1'b0;
                    bus.p_last  = 1'($urandom);
                    step();
                end
                if ($urandom_range(0, 1) == 1) v = {$urandom, $urandom, $urandom};
                else                           v = PW'($urandom_range(0, 1000));
                send_beat(v, (b == nb - 1), to);
                any_to |= to;
                true_sum = true_sum + {{(AW + 4 - PW){1'b0}}, v};
            end
            bus.p_valid = 1'b0;
            bus.p_last  = 1'b0;
            exp_ovf = (|true_sum[AW+3:AW]) || (nb > CMAX);
            exp_cnt = (nb > CMAX) ? CNT_W'(CMAX) : CNT_W'(nb);
`ifdef ACC_SATURATE_EN
            exp_acc = (|true_sum[AW+3:AW]) ? '1 : true_sum[AW-1:0];
`else
            exp_acc = true_sum[AW-1:0];
`endif
            total++;
            if (any_to || bus.acc_valid !== 1'b1 || bus.acc !== exp_acc || bus.acc_count !== exp_cnt || bus.acc_ovf !== exp_ovf) begin
                bad++;
                $display("[TB] FAIL random_frame[%0d]: got valid=%b acc=%0h cnt=%0d ovf=%b required 1/%0h/%0d/%b",
                         f, bus.acc_valid, bus.acc, bus.acc_count, bus.acc_ovf, exp_acc, exp_cnt, exp_ovf);
            end
            repeat ($urandom_range(0, 3)) step();
            total++;
            if (bus.acc_valid !== 1'b1 || bus.acc !== exp_acc) begin
                bad++;
                $display("[TB] FAIL random_hold[%0d]: got valid=%b acc=%0h required 1/%0h",
                         f, bus.acc_valid, bus.acc, exp_acc);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_three_beat();
        test_single_beat();
        test_backpressure();
        test_overflow();
        test_counter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the pipelined array multiplier.
- Accepts a stream of 2*WIDTH-bit unsigned products and sums each frame of products into a guard-extended accumulator.
- Presents the frame sum on a valid/ready output, enabling dot-product and MAC use of the multiplier.
- Frames are delimited by p_last. A valid/ready handshake on both sides lets the multiplier pipeline stall cleanly.

Parameters:
- WIDTH, 48, multiplier operand width; product width PW = 2*WIDTH.
- GUARD, 8, extra accumulator MSBs; accumulator width AW = PW+GUARD.
- CNT_W, 8, width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- p_valid  input  1  product beat valid.
- p  input  PW  unsigned product from the multiplier.
- p_last  input  1  marks the final beat of a frame; qualified by p_valid.
- p_ready  output  1  accumulator can accept a beat.
- acc_valid  output  1  frame result valid.
- acc  output  AW  frame sum.
- acc_count  output  CNT_W  number of beats in the frame.
- acc_ovf  output  1  sticky per-frame overflow (sum carry or counter overflow).
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; acc=0, acc_count=0, acc_ovf=0, acc_valid=0; p_ready=1 from the first clock after deassert.
- States:
  - IDLE: no partial frame.
  - ACCUM: partial frame held.
  - HOLD: result presented.
- Beat transfer occurs when p_valid & p_ready at a clk edge. p_ready = 1 in IDLE/ACCUM, 0 in HOLD; it is a registered function of state and has no combinational path from out_ready.
- IDLE, transfer:
  - acc<=zero-extended p; acc_count<=1; acc_ovf<=0.
  - Next state HOLD if p_last, else ACCUM.
- ACCUM, transfer:
  - acc<=acc+p, computed at AW+1 bits.
  - Carry out of bit AW-1 sets acc_ovf; stored acc wraps mod 2^AW.
  - acc_count<=acc_count+1, saturating at all-ones; an attempted increment past all-ones sets acc_ovf.
  - Next state HOLD if p_last, else ACCUM.
- No transfer: all state held; p_last without p_valid is ignored.
- acc_valid=1 exactly when state is HOLD. Latency: result visible the cycle after the p_last beat is accepted.
- HOLD:
  - acc, acc_count and acc_ovf are stable until the handshake.
  - When acc_valid & out_ready: next state IDLE, acc_valid falls next cycle.
  - Earliest next beat accepted is the cycle after the handshake (one bubble per frame).
- Single-beat frame (p_last on the first beat): acc=p, acc_count=1.
- p_valid during HOLD: beat not consumed; the upstream source holds p and p_last stable.
- Reset mid-frame or in HOLD: partial/pending result discarded, outputs to reset values immediately (asynchronous).
- out_ready outside HOLD: ignored.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined:
  - On a sum carry out of AW bits, acc<=all-ones (2^AW-1) and acc_ovf<=1.
  - Subsequent beats of the same frame leave acc at all-ones.
  - acc_count behaviour unchanged.
- Undefined: sum wraps mod 2^AW as above; acc_ovf is still set on carry.

Test Plan:
- Reset: assert rst mid-frame after 2 beats -> acc=0, acc_count=0, acc_valid=0 immediately; next frame starts clean.
- Frame of 3 beats p=5,7,11, last on 11, out_ready=1 -> acc_valid one cycle after the 3rd beat; acc=23, acc_count=3, acc_ovf=0; p_ready=0 for exactly one cycle.
- Single-beat frame p=2^96-1, last=1 -> acc=2^96-1, acc_count=1.
- Backpressure: out_ready=0 for 5 cycles with p_valid held high -> p_ready=0 and acc stable throughout, no beat lost; after out_ready=1 the held beat starts a new frame.
- Overflow: GUARD=1, two beats of 2^96-1, 2^96-1 -> (AW=97) sum is 2^97-2, no carry, ovf=0; a 3rd beat 2^96-1 gives carry: without macro acc=(3*(2^96-1)) mod 2^97=2^96-3, acc_ovf=1; with ACC_SATURATE_EN acc=2^97-1, acc_ovf=1.
- Counter: CNT_W=2, 4-beat frame of p=1 -> acc=4, acc_count=3 (saturated), acc_ovf=1.
